// File: rtl/fetch_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue_pkg
// Purpose  : Shared types and defaults for the instruction fetch queue.
// Revision : 1.0 - initial release
// ============================================================================
package fetch_queue_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fetch_fifo
// Purpose  : DEPTH-entry circular buffer of fetched instructions with flush.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_fifo
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  fetch_entry_t             push_data,
    input  logic                     pop,
    output fetch_entry_t             head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t   mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [AW:0]    count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the head is masked whenever the buffer is empty.
    always_ff @(posedge clock) begin
        if (push && !flush) mem_q[wr_ptr_q] <= push_data;
    end

    assign head  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue
// Purpose  : Instruction fetch front end: PC sequencing, memory request
//            credit control, redirect discard tracking and a decode queue.
//            Optional same-cycle response bypass: FETCH_QUEUE_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc
);

    localparam int          CW      = $clog2(DEPTH) + 1;
    localparam int          DCW     = CW + 4;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

    logic [31:0]    fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]  inflight_q, inflight_d;
    logic [DCW-1:0] discard_q,  discard_d;
    logic [CW-1:0]  occupancy;
    fetch_entry_t   head;
    fetch_entry_t   push_entry;
    logic           req_fire;
    logic           resp_discard;
    logic           resp_live;
    logic           resp_enq;
    logic           fifo_push;
    logic           fifo_pop;
    logic [31:0]    resp_pc;

    // Credit check counts queued and outstanding live fetches, so every
    // response is guaranteed a free entry.
    assign imem_req_valid = !reset &&
                            (({1'b0, occupancy} + {1'b0, inflight_q}) < DEPTH_W);
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign resp_discard = imem_resp_valid && (discard_q != '0);
    assign resp_live    = imem_resp_valid && (discard_q == '0);
    assign resp_enq     = resp_live && !redirect_valid;

    // Live requests are contiguous and in order, so the oldest one sits
    // inflight words behind the current fetch PC.
    assign resp_pc    = fetch_pc_q - {{(30-CW){1'b0}}, inflight_q, 2'b00};
    assign push_entry = '{pc: resp_pc, inst: imem_resp_data};

    assign fifo_pop = (occupancy != '0) && inst_ready && !redirect_valid;

`ifdef FETCH_QUEUE_BYPASS_EN
    logic bypass;
    assign bypass     = resp_enq && (occupancy == '0) && !reset;
    assign fifo_push  = resp_enq && !(bypass && inst_ready);
    assign inst_valid = !reset && ((occupancy != '0) || bypass);
    assign inst       = (occupancy != '0) ? head.inst :
                        (bypass ? imem_resp_data : 32'h0);
    assign inst_pc    = (occupancy != '0) ? head.pc :
                        (bypass ? resp_pc : 32'h0);
`else
    assign fifo_push  = resp_enq;
    assign inst_valid = !reset && (occupancy != '0);
    assign inst       = head.inst;
    assign inst_pc    = head.pc;
`endif

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        inflight_d = inflight_q;
        discard_d  = discard_q;
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
            inflight_d = '0;
            // Everything still owed by memory becomes stale; this cycle's
            // response (live or stale) is consumed here.
            discard_d  = discard_q + DCW'(inflight_q) + DCW'(req_fire)
                         - DCW'(imem_resp_valid);
        end else begin
            if (req_fire) fetch_pc_d = fetch_pc_q + 32'd4;
            inflight_d = inflight_q + CW'(req_fire) - CW'(resp_live);
            discard_d  = discard_q - DCW'(resp_discard);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            inflight_q <= '0;
            discard_q  <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
        end
    end

    fetch_fifo #(
        .DEPTH     (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .head      (head),
        .count     (occupancy)
    );

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_fetch_queue
// Purpose  : Self-checking bench for fetch_queue against a request-list model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_queue;

    localparam int          DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'h0040_0000;
`ifdef FETCH_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = 32'h0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    always #5 clock = ~clock;

    fetch_queue #(
        .DEPTH           (DEPTH),
        .RESET_PC        (RST_PC)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst            (inst),
        .inst_pc         (inst_pc)
    );

    // Model: list of requests owed by memory (stale after a redirect) and a
    // list of fetched instructions waiting for decode.
    typedef struct { logic [31:0] addr; int due; bit stale; } pend_t;
    typedef struct { logic [31:0] pc; logic [31:0] data; } ent_t;
    typedef struct { logic [31:0] pc; int c; } log_t;

    pend_t       pend[$];
    ent_t        q[$];
    log_t        fire_log[$];
    log_t        dlv_log[$];
    logic [31:0] m_pc = RST_PC;
    int          lat = 1;
    int          last_due = 0;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    function automatic logic [31:0] mkdata(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h3C5A_96E1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input bit redir, input logic [31:0] rpc, input bit rq_rdy, input bit in_rdy);
        pend_t       e;
        pend_t       np;
        ent_t        ne;
        log_t        lg;
        int          livecnt;
        bit          resp, live, byp, exp_rv, exp_iv, fire;
        logic [31:0] exp_inst, exp_ipc;
        e.addr = 32'h0; e.due = 0; e.stale = 1'b0;
        @(negedge clock);
        livecnt = 0;
        foreach (pend[i]) if (!pend[i].stale) livecnt++;
        resp = (pend.size() > 0) && (pend[0].due <= cyc);
        if (resp) e = pend.pop_front();
        redirect_valid  = redir;
        redirect_pc     = rpc;
        imem_req_ready  = rq_rdy;
        inst_ready      = in_rdy;
        imem_resp_valid = resp;
        imem_resp_data  = resp ? mkdata(e.addr) : $urandom;
        #1;
        exp_rv   = (q.size() + livecnt) < DEPTH;
        live     = resp && !e.stale && !redir;
        byp      = BYP && live && (q.size() == 0);
        exp_iv   = (q.size() != 0) || byp;
        exp_inst = (q.size() != 0) ? q[0].data : mkdata(e.addr);
        exp_ipc  = (q.size() != 0) ? q[0].pc   : e.addr;
        chk("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_rv});
        if (exp_rv) chk("req_addr", imem_req_addr, m_pc);
        chk("inst_valid", {31'b0, inst_valid}, {31'b0, exp_iv});
        if (exp_iv) begin
            chk("inst", inst, exp_inst);
            chk("inst_pc", inst_pc, exp_ipc);
        end
        if (imem_req_valid && rq_rdy) begin
            lg.pc = imem_req_addr; lg.c = cyc; fire_log.push_back(lg);
        end
        if (inst_valid && in_rdy && !redir) begin
            lg.pc = inst_pc; lg.c = cyc; dlv_log.push_back(lg);
        end
        fire = exp_rv && rq_rdy;
        np.addr  = m_pc;
        np.due   = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
        np.stale = redir;
        if (redir) begin
            q.delete();
            foreach (pend[i]) pend[i].stale = 1'b1;
            m_pc = rpc & 32'hFFFF_FFFC;
        end else begin
            if (exp_iv && in_rdy && q.size() != 0) void'(q.pop_front());
            if (live && !(byp && in_rdy)) begin
                ne.pc = e.addr; ne.data = mkdata(e.addr); q.push_back(ne);
            end
            if (fire) m_pc = m_pc + 32'd4;
        end
        if (fire) begin
            pend.push_back(np);
            last_due = np.due;
        end
        cyc++;
    endtask

    task automatic do_reset(input int n);
        @(negedge clock);
        #2;
        reset           = 1'b1;
        redirect_valid  = 1'b0;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        inst_ready      = 1'b0;
        #1;
        chk("rst_inst_valid", {31'b0, inst_valid}, 32'h0);
        chk("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_inst_pc", inst_pc, 32'h0);
        q.delete();
        pend.delete();
        m_pc = RST_PC;
        repeat (n) @(negedge clock);
        reset = 1'b0;
        cyc += n + 2;
        last_due = cyc;
    endtask

    initial begin
        // Reset release, latency 1, decode always ready.
        do_reset(3);
        lat = 1;
        fire_log.delete(); dlv_log.delete();
        repeat (10) step(1'b0, 32'h0, 1'b1, 1'b1);
        if (dlv_log.size() >= 3 && fire_log.size() >= 1) begin
            chk("a_pc0", dlv_log[0].pc, 32'h0040_0000);
            chk("a_pc1", dlv_log[1].pc, 32'h0040_0004);
            chk("a_pc2", dlv_log[2].pc, 32'h0040_0008);
            chk("a_gap1", 32'(dlv_log[1].c - dlv_log[0].c), 32'd1);
            chk("a_gap2", 32'(dlv_log[2].c - dlv_log[1].c), 32'd1);
            chk("a_latency", 32'(dlv_log[0].c - fire_log[0].c), BYP ? 32'd1 : 32'd2);
        end else chk("a_delivered", 32'(dlv_log.size()), 32'd3);

        // Decode stalled: exactly DEPTH fires, then drain in order.
        do_reset(2);
        fire_log.delete(); dlv_log.delete();
        repeat (10) step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("b_fires", 32'(fire_log.size()), 32'd4);
        chk("b_req_valid_off", {31'b0, imem_req_valid}, 32'h0);
        fire_log.delete();
        repeat (10) step(1'b0, 32'h0, 1'b1, 1'b1);
        if (dlv_log.size() >= 4 && fire_log.size() >= 1) begin
            for (int i = 0; i < 4; i++)
                chk("b_drain_pc", dlv_log[i].pc, 32'h0040_0000 + 32'(4 * i));
            chk("b_resume_addr", fire_log[0].pc, 32'h0040_0010);
        end else chk("b_drained", 32'(dlv_log.size()), 32'd4);

        // Latency 3, redirect with three requests outstanding.
        do_reset(2);
        lat = 3;
        step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("c_model_pending", 32'(pend.size()), 32'd2);
        dlv_log.delete();
        step(1'b1, 32'h0000_1000, 1'b1, 1'b0);
        repeat (15) step(1'b0, 32'h0, 1'b1, 1'b1);
        if (dlv_log.size() >= 1) chk("c_first_pc", dlv_log[0].pc, 32'h0000_1000);
        else chk("c_delivered", 32'(dlv_log.size()), 32'd1);

        // Redirect coinciding with a response and a request fire.
        do_reset(2);
        lat = 2;
        step(1'b0, 32'h0, 1'b1, 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b1);
        dlv_log.delete();
        step(1'b1, 32'h0000_2000, 1'b1, 1'b1);
        repeat (12) step(1'b0, 32'h0, 1'b1, 1'b1);
        if (dlv_log.size() >= 1) chk("d_first_pc", dlv_log[0].pc, 32'h0000_2000);
        else chk("d_delivered", 32'(dlv_log.size()), 32'd1);

        // Address wrap, then reset in the middle of a stream.
        lat = 1;
        step(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1);
        fire_log.delete();
        repeat (4) step(1'b0, 32'h0, 1'b1, 1'b1);
        if (fire_log.size() >= 2) begin
            chk("e_wrap0", fire_log[0].pc, 32'hFFFF_FFFC);
            chk("e_wrap1", fire_log[1].pc, 32'h0000_0000);
        end else chk("e_fires", 32'(fire_log.size()), 32'd2);
        repeat (4) step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("e_pre_reset_valid", {31'b0, inst_valid}, 32'h1);
        do_reset(2);
        fire_log.delete(); dlv_log.delete();
        repeat (6) step(1'b0, 32'h0, 1'b1, 1'b1);
        if (fire_log.size() >= 1 && dlv_log.size() >= 1) begin
            chk("e_restart_addr", fire_log[0].pc, 32'h0040_0000);
            chk("e_restart_pc", dlv_log[0].pc, 32'h0040_0000);
        end else chk("e_restart", 32'(dlv_log.size()), 32'd1);

        // Randomized traffic.
        for (int n = 0; n < 4000; n++) begin
            if (n % 250 == 0) lat = $urandom_range(1, 4);
            if ($urandom_range(0, 999) < 3) do_reset($urandom_range(1, 3));
            else step($urandom_range(0, 99) < 4, $urandom,
                      $urandom_range(0, 99) < 75, $urandom_range(0, 99) < 65);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning queue entries and maximum in-flight fetches (power of two, 2..16).
REQ-002 SHALL have parameter RESET_PC, default 32'h0040_0000, meaning the first fetch address after reset.
REQ-003 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port redirect_valid, input, 1, a taken branch, jump or trap requests a new fetch stream.
REQ-006 SHALL have port redirect_pc, input, 32, the target of the new stream.
REQ-007 SHALL have ports imem_req_valid (output, 1), imem_req_ready (input, 1) and imem_req_addr (output, 32), the instruction-memory request handshake.
REQ-008 SHALL have ports imem_resp_valid (input, 1) and imem_resp_data (input, 32), in-order responses with latency of at least 1 cycle and no backpressure.
REQ-009 SHALL have ports inst_valid (output, 1), inst_ready (input, 1), inst (output, 32) and inst_pc (output, 32), the decode/immediate-generation side handshake.

Function
REQ-010 SHALL fire a request when imem_req_valid && imem_req_ready, with imem_req_addr = fetch_pc; fetch_pc SHALL advance by 4 per fire (mod 2^32, wrapping 0xFFFF_FFFC -> 0).
REQ-011 SHALL assert imem_req_valid iff occupancy + inflight < DEPTH and reset is low, so every response always has a free entry.
REQ-012 SHALL count a response as a discard while discard_cnt > 0; it then decrements discard_cnt and leaves the queue untouched.
REQ-013 SHALL enqueue a non-discard response as {pc of its request, data} and decrement inflight.
REQ-014 SHALL drive inst_valid = (occupancy != 0), with inst/inst_pc taken from the head entry; a dequeue occurs on inst_valid && inst_ready.
REQ-015 SHALL handle a same-cycle enqueue and dequeue: occupancy unchanged; a full queue with a simultaneous dequeue cannot overflow because of REQ-011.
REQ-016 On redirect_valid, SHALL flush the queue to occupancy 0 and set fetch_pc <= redirect_pc.
REQ-017 On redirect_valid, SHALL set discard_cnt <= discard_cnt + inflight + req_fire - resp_fire and inflight <= 0; the response that cycle is dropped.
REQ-018 SHALL ignore the inst_ready dequeue in a redirect cycle.
REQ-019 SHALL drop bits [1:0] of redirect_pc (forced to 0); no misalignment trap is raised here.
REQ-020 SHALL give a fetch-to-inst_valid latency of memory latency + 1 cycle (bypass disabled).

Reset
REQ-021 While reset is high, SHALL hold fetch_pc = RESET_PC, occupancy, inflight and discard_cnt = 0, imem_req_valid = 0, inst_valid = 0 and inst/inst_pc = 0, taking effect immediately.
REQ-022 SHALL apply reset mid-operation with the same REQ-021 effects; responses arriving after deassertion for pre-reset requests are the memory's responsibility (the memory is reset together with this block).

Configuration
REQ-023 With macro FETCH_QUEUE_BYPASS_EN defined, a non-discard response arriving while occupancy == 0 and no redirect SHALL drive inst_valid = 1, inst = imem_resp_data and inst_pc = its pc in the same cycle; if inst_ready it is not enqueued (latency = memory latency).
REQ-024 With FETCH_QUEUE_BYPASS_EN undefined, SHALL have no combinational path from imem_resp_* to inst_*, and the latency is per REQ-020.

Structure
REQ-025 SHALL place the typedef fetch_entry_t {pc[31:0], inst[31:0]} and the localparam RESET_PC default in the shared core package.
REQ-026 SHALL have one sub-module, fetch_fifo (DEPTH entries of fetch_entry_t, push/pop/flush, count output); counters and the PC stay in fetch_queue.

Verification
REQ-027 Reset release with memory latency 1 and inst_ready = 1 SHALL produce inst_pc sequence 0x00400000, 0x00400004, 0x00400008 on consecutive cycles after fill, with one instruction every cycle.
REQ-028 inst_ready = 0 and DEPTH = 4 SHALL give exactly 4 fires and then imem_req_valid = 0; raising inst_ready SHALL deliver 4 entries in order, after which fetching resumes.
REQ-029 Memory latency 3 with 3 in flight and redirect_pc = 0x00001000 SHALL drop the next 3 responses; the first inst_pc delivered is 0x00001000.
REQ-030 Redirect in the same cycle as a response and a request fire SHALL drop that response, set discard_cnt to the in-flight count including the new fire, and never deliver a stale pc.
REQ-031 fetch_pc = 0xFFFFFFFC SHALL make the next request address 0x00000000; asserting reset mid-stream SHALL drop inst_valid immediately and restart at 0x00400000.
REQ-032 Under FETCH_QUEUE_BYPASS_EN with the queue empty, a response SHALL appear on inst in the same cycle; with the macro undefined it appears one cycle later.
